rv32i_mem_arb: RTL and testbench
================================

Name: rv32i_mem_arb

Overview:
- Arbiter and sequencer that shares one single-port memory between the instruction-fetch port and the load/store unit's data port.
- Muxes address, write data, byte enables and write enable onto the memory bus.
- Tracks one outstanding read with a latency counter and routes returned read data back to the owning requester.
- Sits between the fetch stage and the LSU on one side and the unified instruction/data memory on the other.

Parameters:
- MEM_LATENCY, 1, cycles from the accepted read request to valid mem_rdata_i. Legal range 1..7.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- if_req_i  in  1  fetch request; held until granted.
- if_addr_i  in  32  fetch address, word aligned.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid this cycle.
- if_rdata_o  out  32  fetch read data.
- d_req_i  in  1  data request; held until granted.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  32  data address from the LSU.
- d_wdata_i  in  32  store data, already lane-shifted by the LSU.
- d_be_i  in  4  byte enables from the LSU (be3..be0).
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  load data valid this cycle.
- d_rdata_o  out  32  raw load word; the LSU extracts and extends it.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_be_o  out  4  memory byte enables.
- mem_gnt_i  in  1  memory accepts the request this cycle; low inserts wait states.
- mem_rdata_i  in  32  memory read data.

Behaviour:
- FSM states: IDLE, WAIT. Registered state: FSM state, 3-bit latency counter, owner bit (0 = fetch, 1 = data), last_owner bit. Reset clears all to IDLE/0.
- Reset outputs: every gnt, rvalid, mem_req_o and mem_we_o is 0. mem_addr_o, mem_wdata_o and mem_be_o are 0. if_rdata_o and d_rdata_o are 0.
- IDLE:
  - mem_req_o = if_req_i | d_req_i (combinational).
  - Selection (default build): data port wins when both request.
  - Data selected: bus driven from d_* inputs.
  - Fetch selected: mem_addr_o = if_addr_i, mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
  - No request: all bus outputs 0.
- Accept: a request is accepted when mem_req_o && mem_gnt_i. The selected port's gnt_o = 1 in that same cycle; the other gnt_o = 0.
- Wait states: if mem_gnt_i = 0, no gnt is given and the arbitration decision is recomputed every cycle. A higher-priority request arriving during wait states may win.
- Accepted write: single cycle, FSM stays IDLE, no rvalid is ever generated. Back-to-back writes at one per cycle are legal.
- Accepted read:
  - Latch owner, load counter = MEM_LATENCY, go to WAIT.
  - In WAIT: mem_req_o = 0, bus outputs 0, both gnt_o = 0. Requesters keep their req asserted.
  - Counter decrements each cycle in WAIT. In the cycle the counter reaches 1, exactly MEM_LATENCY cycles after acceptance:
    - owner rvalid_o = 1 and owner rdata_o = mem_rdata_i;
    - FSM returns to IDLE on the next edge.
  - No new request is issued in the rvalid cycle, so read-to-next-request gap = MEM_LATENCY + 1 cycles.
- Non-owner rdata_o = 0. Owner rdata_o = 0 outside its rvalid cycle.
- last_owner updates on every accept, both reads and writes.
- rst_i asserted in WAIT: the pending read is discarded, no rvalid is produced, FSM is IDLE on the next cycle.
- Simultaneous events: d_req_i and if_req_i both high with mem_gnt_i high → exactly one gnt. Both gnt_o never high in the same cycle, and both rvalid_o never high in the same cycle.
- Requests arriving in WAIT are ignored (not latched); they are served from IDLE only.
- No address alignment checking; d_addr_i passes unmodified.

Optional Feature:
- Macro: RV32I_ARB_ROUND_ROBIN_EN.
- Defined: on contention in IDLE, the port that did not win the last accept (per last_owner) is selected, so the ports alternate under continuous contention. A single requester is always served.
- Undefined: fixed priority with the data port always winning, and last_owner is unused.

Test Plan:
- Reset check: rst_i = 1 for 2 cycles with both req high → all gnt/rvalid/mem_req_o = 0. First IDLE cycle after release: d_gnt_o = 1.
- Fetch read, MEM_LATENCY = 2:
  - Stimulus: if_req_i = 1, if_addr_i = 0x0000_0100, mem_gnt_i = 1.
  - Cycle 0: if_gnt_o = 1, mem_be_o = 4'hF, mem_we_o = 0.
  - Cycle 2: if_rvalid_o = 1 and if_rdata_o = mem_rdata_i = 0xDEAD_BEEF; d_rvalid_o = 0.
- Byte store: d_req_i = 1, d_we_i = 1, d_addr_i = 0x0000_0203, d_be_i = 4'b1000, d_wdata_i = 0xAB00_0000 → one-cycle accept, mem_be_o = 4'b1000, no rvalid. Second store in the next cycle is accepted immediately.
- Contention, default build: both req high every cycle, loads, MEM_LATENCY = 1 → data granted at cycles 0, 2, 4; fetch never granted while d_req_i stays high.
- Contention with RV32I_ARB_ROUND_ROBIN_EN, MEM_LATENCY = 1 → grants alternate data, fetch, data at cycles 0, 2, 4. rvalid goes to the matching port at cycles 1, 3, 5.
- Wait states and reset mid-read:
  - mem_gnt_i = 0 for 3 cycles with d_req_i held → no gnt; accept on the 4th cycle.
  - MEM_LATENCY = 3 with rst_i pulsed 1 cycle after accept → no d_rvalid_o ever; next request accepted from IDLE.

Source files
------------

// File: rtl/rv32i_mem_arb.sv
// rtl/rv32i_mem_arb.sv - shares one single-port memory between instruction fetch and the LSU data port.
// Optional round-robin arbitration on contention: RV32I_ARB_ROUND_ROBIN_EN.
module rv32i_mem_arb #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_be_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       sel_data;
    logic       accept;
    logic       rd_done;

`ifdef RV32I_ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On contention the port that lost the previous accept goes first.
    assign sel_data = d_req_i & ~(if_req_i & last_owner_q);

    always_comb begin
        last_owner_d = last_owner_q;
        if (accept) begin
            last_owner_d = sel_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign sel_data = d_req_i;
`endif

    assign accept  = (state_q == IDLE) && (if_req_i || d_req_i) && mem_gnt_i && !rst_i;
    assign rd_done = (state_q == WAIT) && (cnt_q == 3'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                // Writes complete in the accept cycle; only reads wait for data.
                if (accept && !(sel_data && d_we_i)) begin
                    state_d = WAIT;
                    cnt_d   = LAT;
                    owner_d = sel_data;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (rd_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        if_rdata_o  = 32'h0;
        d_rdata_o   = 32'h0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        mem_be_o    = 4'h0;
        if (!rst_i) begin
            if (state_q == IDLE) begin
                mem_req_o = if_req_i | d_req_i;
                if (sel_data) begin
                    mem_we_o    = d_we_i;
                    mem_addr_o  = d_addr_i;
                    mem_wdata_o = d_wdata_i;
                    mem_be_o    = d_be_i;
                end else if (if_req_i) begin
                    mem_addr_o = if_addr_i;
                    mem_be_o   = 4'hF;
                end
                if_gnt_o = accept & ~sel_data;
                d_gnt_o  = accept & sel_data;
            end else if (rd_done) begin
                if (owner_q) begin
                    d_rvalid_o = 1'b1;
                    d_rdata_o  = mem_rdata_i;
                end else begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arb.sv
// tb/tb_rv32i_mem_arb.sv - self-checking bench for rv32i_mem_arb against a cycle-count reference model.
module tb_rv32i_mem_arb;

    localparam int LAT = 2;
`ifdef RV32I_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic [31:0] mem_rdata_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: absolute cycle index of the pending read's data return.
    int cyc     = 0;
    bit m_pend  = 1'b0;
    int m_ret   = 0;
    bit m_owner = 1'b0;
    bit m_last  = 1'b0;
    bit e_if_gnt = 1'b0;
    bit e_d_gnt  = 1'b0;

    rv32i_mem_arb #(.MEM_LATENCY(LAT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_be_i      (d_be_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    always @(negedge clk_i) begin : cmp
        logic [9:0]  ec;
        logic [9:0]  ac;
        logic [31:0] ea, ew, eir, edr;
        logic        pick_d, acc;
        ec = '0; ea = '0; ew = '0; eir = '0; edr = '0;
        pick_d = 1'b0; acc = 1'b0;
        if (!rst_i) begin
            if (m_pend) begin
                if (cyc == m_ret) begin
                    if (m_owner) begin
                        ec[6] = 1'b1; edr = mem_rdata_i;
                    end else begin
                        ec[7] = 1'b1; eir = mem_rdata_i;
                    end
                end
            end else if (if_req_i || d_req_i) begin
                pick_d = d_req_i && !(RR && if_req_i && m_last);
                acc    = mem_gnt_i;
                ec[5]  = 1'b1;
                if (pick_d) begin
                    ec[4] = d_we_i; ec[3:0] = d_be_i; ea = d_addr_i; ew = d_wdata_i;
                end else begin
                    ec[3:0] = 4'hF; ea = if_addr_i;
                end
                ec[9] = acc && !pick_d;
                ec[8] = acc && pick_d;
            end
        end
        ac = {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, mem_req_o, mem_we_o, mem_be_o};
        chk("model_ctrl", {22'h0, ac}, {22'h0, ec});
        chk("model_addr", mem_addr_o, ea);
        chk("model_wdata", mem_wdata_o, ew);
        chk("model_if_rdata", if_rdata_o, eir);
        chk("model_d_rdata", d_rdata_o, edr);
        e_if_gnt = ec[9];
        e_d_gnt  = ec[8];
        if (rst_i) begin
            m_pend = 1'b0;
            m_last = 1'b0;
        end else if (m_pend) begin
            if (cyc == m_ret) m_pend = 1'b0;
        end else if (acc) begin
            m_last = pick_d;
            if (!(pick_d && d_we_i)) begin
                m_pend  = 1'b1;
                m_owner = pick_d;
                m_ret   = cyc + LAT;
            end
        end
        cyc++;
    end

    initial begin
        rst_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h100;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_wdata_i = 32'h55; d_be_i = 4'hF;
        mem_gnt_i = 1'b1; mem_rdata_i = 32'h0;

        step(); look();
        chk("rst_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h0);
        step(); look();
        chk("rst_rvalid", {30'h0, if_rvalid_o, d_rvalid_o}, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);

        step(); rst_i = 1'b0; look();
        chk("first_dgnt", {31'h0, d_gnt_o}, 32'h1);
        chk("first_ifgnt", {31'h0, if_gnt_o}, 32'h0);
        chk("first_addr", mem_addr_o, 32'h200);

        step(); d_req_i = 1'b0; mem_rdata_i = 32'h1111_2222; look();
        chk("wait_req", {31'h0, mem_req_o}, 32'h0);
        chk("wait_ifgnt", {31'h0, if_gnt_o}, 32'h0);
        step(); look();
        chk("d_rvalid", {31'h0, d_rvalid_o}, 32'h1);
        chk("d_rdata", d_rdata_o, 32'h1111_2222);
        chk("if_rv_quiet", {31'h0, if_rvalid_o}, 32'h0);

        step(); look();
        chk("if_gnt", {31'h0, if_gnt_o}, 32'h1);
        chk("if_be", {28'h0, mem_be_o}, 32'hF);
        chk("if_we", {31'h0, mem_we_o}, 32'h0);
        chk("if_addr", mem_addr_o, 32'h100);
        step(); if_req_i = 1'b0; mem_rdata_i = 32'hDEAD_BEEF; look();
        chk("if_rv_early", {31'h0, if_rvalid_o}, 32'h0);
        step(); look();
        chk("if_rvalid", {31'h0, if_rvalid_o}, 32'h1);
        chk("if_rdata", if_rdata_o, 32'hDEAD_BEEF);
        chk("if_rv_d_quiet", {31'h0, d_rvalid_o}, 32'h0);

        step(); d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h203; d_be_i = 4'b1000;
        d_wdata_i = 32'hAB00_0000; look();
        chk("st1_gnt", {31'h0, d_gnt_o}, 32'h1);
        chk("st1_be", {28'h0, mem_be_o}, 32'h8);
        chk("st1_we", {31'h0, mem_we_o}, 32'h1);
        chk("st1_wdata", mem_wdata_o, 32'hAB00_0000);
        chk("st1_addr", mem_addr_o, 32'h203);
        step(); d_addr_i = 32'h204; d_be_i = 4'hF; d_wdata_i = 32'h1234_5678; look();
        chk("st2_gnt", {31'h0, d_gnt_o}, 32'h1);
        chk("st2_wdata", mem_wdata_o, 32'h1234_5678);
        step(); d_req_i = 1'b0; look();
        chk("st_no_rv", {30'h0, if_rvalid_o, d_rvalid_o}, 32'h0);

        step(); d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300; mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            look();
            chk("ws_no_gnt", {31'h0, d_gnt_o}, 32'h0);
            chk("ws_req", {31'h0, mem_req_o}, 32'h1);
        end
        step(); mem_gnt_i = 1'b1; look();
        chk("ws_accept", {31'h0, d_gnt_o}, 32'h1);
        step(); rst_i = 1'b1; d_addr_i = 32'h400; look();
        chk("rst_mid_rv", {31'h0, d_rvalid_o}, 32'h0);
        step(); rst_i = 1'b0; look();
        chk("post_rst_gnt", {31'h0, d_gnt_o}, 32'h1);
        chk("post_rst_no_rv", {31'h0, d_rvalid_o}, 32'h0);
        step(); d_req_i = 1'b0; look();
        chk("post_rst_wait", {31'h0, d_rvalid_o}, 32'h0);
        step(); look();
        chk("post_rst_rv", {31'h0, d_rvalid_o}, 32'h1);

        // Continuous contention of loads; last accept was the data port.
        step(); d_req_i = 1'b1; if_req_i = 1'b1; d_we_i = 1'b0; if_addr_i = 32'h500;
        for (int k = 0; k < 9; k++) begin
            logic [1:0] eg;
            if (k > 0) step();
            look();
            eg = 2'b00;
            if (k % 3 == 0) begin
                if (RR && ((k / 3) % 2 == 0)) eg = 2'b10;
                else eg = 2'b01;
            end
            chk("contend_gnt", {30'h0, if_gnt_o, d_gnt_o}, {30'h0, eg});
        end

        for (int r = 0; r < 3000; r++) begin
            step();
            rst_i       = ($urandom_range(0, 63) == 0);
            mem_gnt_i   = ($urandom_range(0, 3) != 0);
            mem_rdata_i = $urandom;
            if (!if_req_i || e_if_gnt) begin
                if_req_i  = 1'($urandom_range(0, 1));
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req_i || e_d_gnt) begin
                d_req_i   = 1'($urandom_range(0, 1));
                d_we_i    = 1'($urandom_range(0, 1));
                d_addr_i  = $urandom;
                d_wdata_i = $urandom;
                d_be_i    = 4'($urandom);
            end
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
